idc_pixel_port: RTL and testbench
=================================

# idc_pixel_port

Pixel memory access port for the down-sampling processor. It sits between the control unit and data memory. On a load or store request it takes the current row/column index registers (read pair RRR/CRR or write pair RWR/CWR), turns them into a linear memory address, and runs a req/ack transaction with data memory. It then reports completion, or an error, back to the control unit.

## Interface
Parameters:
- IMG_WIDTH, 256: pixels per row; also the row stride.
- IMG_HEIGHT, 256: rows in the image.
- ADDR_W, 16: memory address width.
- TIMEOUT, 15: maximum wait cycles for mem_ack before aborting.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  control unit requests an access; sampled only when op_ready=1.
- op_write  in  1  0 = load pixel at (rrr,crr); 1 = store wdata at (rwr,cwr).
- rrr, crr  in  8 each  read row / read column index.
- rwr, cwr  in  8 each  write row / write column index.
- wdata  in  8  pixel to store.
- op_ready  out  1  high in IDLE only.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on range fault or timeout.
- rdata  out  8  last successfully loaded pixel; held until the next successful load.
- mem_req  out  1  memory request; held high until ack or timeout.
- mem_we  out  1  write strobe qualifier, valid while mem_req=1.
- mem_addr  out  ADDR_W  linear address, valid while mem_req=1.
- mem_wdata  out  8  store data, valid while mem_req=1.
- mem_ack  in  1  memory completion; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  in  8  load data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - op_ready=1.
  - On op_valid=1, latch op_write, the selected row/col pair and wdata.
  - Compute addr = row*IMG_WIDTH + col, width ADDR_W; the product is formed at ADDR_W+8 bits and truncated.
  - Range fault if row ≥ IMG_HEIGHT or col ≥ IMG_WIDTH. On a fault, go to RESP with the error flag set; no memory access is issued.
  - Otherwise go to ACCESS and clear the wait counter.
- ACCESS:
  - mem_req=1; mem_we, mem_addr and mem_wdata are driven from the latched values and are stable for the whole state.
  - mem_ack=1: on a load, capture mem_rdata into rdata; go to RESP.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT without ack, set the error flag and go to RESP; rdata is unchanged.
- RESP:
  - done=1, and err=1 if the error flag is set.
  - Always returns to IDLE next cycle.
- Inputs that change after acceptance do not affect the transaction in flight.
- mem_ack arriving outside ACCESS is ignored.
- Reset (any state, including mid-ACCESS):
  - Next state is IDLE; op_ready=1.
  - done, err, mem_req, mem_we = 0.
  - mem_addr, mem_wdata, rdata = 0; wait counter = 0.
  - An aborted transaction produces no done.

## Timing
- Cycle 0: op_valid=1 while op_ready=1, sampled at the edge.
- Cycle 1: mem_req=1 and op_ready=0.
- With ack in cycle 1+k (k ≥ 0): done=1 in cycle 2+k, and rdata is updated in that same cycle. Minimum latency is request to done = 2 cycles.
- Range fault: done=err=1 in cycle 1; mem_req never asserts.
- Timeout: mem_req is high for exactly TIMEOUT+1 cycles (cycles 1..TIMEOUT+1). done=err=1 in cycle TIMEOUT+2.
  - An ack in the final cycle (TIMEOUT+1) counts as success; ack is checked before the timeout.
- op_ready returns to 1 in the cycle after done, so back-to-back requests have a minimum spacing of 3 cycles.
- Registered outputs only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: after reset, op_ready=1 and all other outputs are 0. Hold op_valid=0 for 20 cycles → no mem_req and no done.
- Load, zero wait: rrr=3, crr=5, op_write=0, memory acks immediately with 0xA7 → mem_addr=0x0305, mem_we=0; done 2 cycles after the request; rdata=0xA7, err=0.
- Store, wait: rwr=255, cwr=255, wdata=0x3C, ack after 4 cycles → mem_addr=0xFFFF, mem_we=1, mem_wdata=0x3C held for 5 cycles; done in cycle 6; rdata unchanged.
- Range fault: IMG_WIDTH=128, IMG_HEIGHT=128, crr=200 → done=err=1 in cycle 1, mem_req stays 0. A following valid load at (1,2) → mem_addr=130.
- Timeout boundary:
  - No ack → mem_req high for 16 cycles, done=err=1 in cycle 17, rdata unchanged.
  - Ack in the 16th req cycle → success, err=0.
- Reset mid-ACCESS: assert reset in the 3rd req cycle → next cycle mem_req=0, op_ready=1, no done. A fresh load then completes normally.

Source files
------------

// File: rtl/idc_pixel_port.sv
// rtl/idc_pixel_port.sv - pixel memory access port: index pair to linear address, req/ack with timeout
module idc_pixel_port #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int ADDR_W     = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_write,
    input  logic [7:0]        rrr,
    input  logic [7:0]        crr,
    input  logic [7:0]        rwr,
    input  logic [7:0]        cwr,
    input  logic [7:0]        wdata,
    output logic              op_ready,
    output logic              done,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);
    localparam int CNT_W  = $clog2(TIMEOUT + 1) + 1;
    localparam int PROD_W = ADDR_W + 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic [7:0]        w_row;
    logic [7:0]        w_col;
    logic [ADDR_W-1:0] w_addr;
    logic              w_fault;
    logic              w_timeout;

    assign w_row     = op_write ? rwr : rrr;
    assign w_col     = op_write ? cwr : crr;
    // Product is formed wide and then truncated to the memory address width.
    assign w_addr    = ADDR_W'(PROD_W'(w_row) * PROD_W'(IMG_WIDTH) + PROD_W'(w_col));
    assign w_fault   = (32'(w_row) >= IMG_HEIGHT) || (32'(w_col) >= IMG_WIDTH);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (op_valid) w_next = w_fault ? RESP : ACCESS;
            ACCESS:  if (mem_ack || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_valid) begin
                        r_we    <= op_write;
                        r_addr  <= w_addr;
                        r_wdata <= wdata;
                        r_err   <= w_fault;
                        r_cnt   <= '0;
                    end
                end
                ACCESS: begin
                    // An ack in the last allowed cycle wins over the timeout.
                    if (mem_ack) begin
                        if (!r_we) r_rdata <= mem_rdata;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_ready  = (r_state == IDLE);
    assign mem_req   = (r_state == ACCESS);
    assign mem_we    = r_we && (r_state == ACCESS);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign done      = (r_state == RESP);
    assign err       = r_err && (r_state == RESP);
    assign rdata     = r_rdata;
endmodule

// File: tb/tb_idc_pixel_port.sv
// tb/tb_idc_pixel_port.sv - scoreboard bench for idc_pixel_port (256x256 and 128x128 instances)
module tb_idc_pixel_port;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset, op_valid, op_write, mem_ack, sel;
    logic [7:0] rrr, crr, rwr, cwr, wdata, mem_rdata;

    logic b_op_ready, b_done, b_err, b_mem_req, b_mem_we;
    logic [7:0] b_rdata, b_mem_wdata;
    logic [15:0] b_mem_addr;
    logic s_op_ready, s_done, s_err, s_mem_req, s_mem_we;
    logic [7:0] s_rdata, s_mem_wdata;
    logic [15:0] s_mem_addr;

    logic o_op_ready, o_done, o_err, o_mem_req, o_mem_we;
    logic [7:0] o_rdata, o_mem_wdata;
    logic [15:0] o_mem_addr;

    always #5 clk = ~clk;

    idc_pixel_port u_big (
        .clock(clk), .reset(reset), .op_valid(op_valid), .op_write(op_write),
        .rrr(rrr), .crr(crr), .rwr(rwr), .cwr(cwr), .wdata(wdata),
        .op_ready(b_op_ready), .done(b_done), .err(b_err), .rdata(b_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    idc_pixel_port #(.IMG_WIDTH(128), .IMG_HEIGHT(128)) u_sml (
        .clock(clk), .reset(reset), .op_valid(op_valid), .op_write(op_write),
        .rrr(rrr), .crr(crr), .rwr(rwr), .cwr(cwr), .wdata(wdata),
        .op_ready(s_op_ready), .done(s_done), .err(s_err), .rdata(s_rdata),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    assign o_op_ready  = sel ? s_op_ready  : b_op_ready;
    assign o_done      = sel ? s_done      : b_done;
    assign o_err       = sel ? s_err       : b_err;
    assign o_rdata     = sel ? s_rdata     : b_rdata;
    assign o_mem_req   = sel ? s_mem_req   : b_mem_req;
    assign o_mem_we    = sel ? s_mem_we    : b_mem_we;
    assign o_mem_addr  = sel ? s_mem_addr  : b_mem_addr;
    assign o_mem_wdata = sel ? s_mem_wdata : b_mem_wdata;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wd;
        int          n_req;
        int          done_cyc;
        logic        err;
        logic [7:0]  rdata;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] m_rdata = 8'h00;

    logic [15:0] obs_addr;
    logic        obs_we, obs_err, obs_stable, obs_ready0, obs_ready_done;
    logic [7:0]  obs_wd, obs_rdata;
    int          obs_nreq, obs_done;

    task automatic push_exp(input int row, input int col, input logic we, input logic [7:0] wd,
                            input int ack_k, input logic [7:0] rd, input int w, input int h);
        exp_t e;
        e.addr = 16'(row * w + col);
        e.we   = we;
        e.wd   = wd;
        if (row >= h || col >= w) begin
            e.n_req = 0; e.done_cyc = 1; e.err = 1'b1;
        end else if (ack_k < 0 || ack_k > TMO) begin
            e.n_req = TMO + 1; e.done_cyc = TMO + 2; e.err = 1'b1;
        end else begin
            e.n_req = ack_k + 1; e.done_cyc = ack_k + 2; e.err = 1'b0;
            if (!we) m_rdata = rd;
        end
        e.rdata = m_rdata;
        sb.push_back(e);
    endtask

    task automatic run_op(input int row, input int col, input logic we, input logic [7:0] wd,
                          input int ack_k, input logic [7:0] rd);
        @(negedge clk);
        obs_ready0 = o_op_ready;
        op_write = we;
        wdata = wd;
        if (we) begin
            rwr = 8'(row); cwr = 8'(col); rrr = ~8'(row); crr = ~8'(col);
        end else begin
            rrr = 8'(row); crr = 8'(col); rwr = ~8'(row); cwr = ~8'(col);
        end
        op_valid = 1'b1;
        obs_nreq = 0; obs_done = -1; obs_err = 1'b0; obs_stable = 1'b1; obs_ready_done = 1'b1;
        obs_addr = '0; obs_we = 1'b0; obs_wd = '0; obs_rdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (c == 1) begin
                op_valid = 1'b0; op_write = ~we; wdata = 8'($urandom);
                rrr = 8'($urandom); crr = 8'($urandom); rwr = 8'($urandom); cwr = 8'($urandom);
            end
            if (o_mem_req) begin
                if (obs_nreq == 0) begin
                    obs_addr = o_mem_addr; obs_we = o_mem_we; obs_wd = o_mem_wdata;
                end else if (o_mem_addr !== obs_addr || o_mem_we !== obs_we || o_mem_wdata !== obs_wd) begin
                    obs_stable = 1'b0;
                end
                obs_nreq++;
                if (c == ack_k + 1) begin
                    mem_ack = 1'b1; mem_rdata = rd;
                end
            end
            if (o_done) begin
                obs_done = c; obs_err = o_err; obs_rdata = o_rdata; obs_ready_done = o_op_ready;
                break;
            end
        end
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
    endtask

    task automatic score(input string name);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++; $display("FAIL %s sb_empty: no expected entry", name); return;
        end
        e = sb.pop_front();
        if (obs_done !== e.done_cyc) begin
            n_bad++; $display("FAIL %s done_cycle: got %0d want %0d", name, obs_done, e.done_cyc);
        end
        n_vec++;
        if (obs_err !== e.err) begin
            n_bad++; $display("FAIL %s err: got %b want %b", name, obs_err, e.err);
        end
        n_vec++;
        if (obs_nreq !== e.n_req) begin
            n_bad++; $display("FAIL %s req_cycles: got %0d want %0d", name, obs_nreq, e.n_req);
        end
        n_vec++;
        if (obs_rdata !== e.rdata) begin
            n_bad++; $display("FAIL %s rdata: got %h want %h", name, obs_rdata, e.rdata);
        end
        n_vec++;
        if (obs_ready0 !== 1'b1 || obs_ready_done !== 1'b0) begin
            n_bad++; $display("FAIL %s op_ready: got start=%b done=%b want 1/0", name, obs_ready0, obs_ready_done);
        end
        if (e.n_req > 0) begin
            n_vec++;
            if (obs_addr !== e.addr || obs_we !== e.we) begin
                n_bad++; $display("FAIL %s addr_we: got %h/%b want %h/%b", name, obs_addr, obs_we, e.addr, e.we);
            end
            n_vec++;
            if (!obs_stable) begin
                n_bad++; $display("FAIL %s req_stable: got unstable want stable", name);
            end
            if (e.we) begin
                n_vec++;
                if (obs_wd !== e.wd) begin
                    n_bad++; $display("FAIL %s mem_wdata: got %h want %h", name, obs_wd, e.wd);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({b_op_ready, b_done, b_err, b_mem_req, b_mem_we} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 10000", {b_op_ready, b_done, b_err, b_mem_req, b_mem_we});
        end
        n_vec++;
        if (b_mem_addr !== 16'h0 || b_mem_wdata !== 8'h0 || b_rdata !== 8'h0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", b_mem_addr, b_mem_wdata, b_rdata);
        end
    endtask

    task automatic test_idle;
        int n_req, n_done;
        n_req = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ack = (c == 7);
            mem_rdata = 8'hEE;
            if (b_mem_req) n_req++;
            if (b_done) n_done++;
        end
        mem_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (n_req != 0 || n_done != 0) begin
            n_bad++; $display("FAIL idle_activity: got req=%0d done=%0d want 0/0", n_req, n_done);
        end
        n_vec++;
        if (b_rdata !== m_rdata) begin
            n_bad++; $display("FAIL idle_stray_ack: got rdata %h want %h", b_rdata, m_rdata);
        end
    endtask

    task automatic test_load_zero_wait;
        push_exp(3, 5, 1'b0, 8'h00, 0, 8'hA7, 256, 256);
        run_op(3, 5, 1'b0, 8'h00, 0, 8'hA7);
        score("load_zero_wait");
    endtask

    task automatic test_store_wait;
        push_exp(255, 255, 1'b1, 8'h3C, 4, 8'h99, 256, 256);
        run_op(255, 255, 1'b1, 8'h3C, 4, 8'h99);
        score("store_wait");
    endtask

    task automatic test_range_fault;
        int n_req;
        sel = 1'b1;
        push_exp(4, 200, 1'b0, 8'h00, 0, 8'h11, 128, 128);
        run_op(4, 200, 1'b0, 8'h00, 0, 8'h11);
        score("range_fault");
        n_req = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_mem_req) n_req++;
        end
        n_vec++;
        if (n_req != 0) begin
            n_bad++; $display("FAIL range_no_req: got %0d req cycles want 0", n_req);
        end
        push_exp(1, 2, 1'b0, 8'h00, 0, 8'h61, 128, 128);
        run_op(1, 2, 1'b0, 8'h00, 0, 8'h61);
        score("range_after_load");
        sel = 1'b0;
    endtask

    task automatic test_timeout;
        push_exp(10, 10, 1'b0, 8'h00, -1, 8'h22, 256, 256);
        run_op(10, 10, 1'b0, 8'h00, -1, 8'h22);
        score("timeout_no_ack");
        push_exp(20, 30, 1'b0, 8'h00, TMO, 8'h5D, 256, 256);
        run_op(20, 30, 1'b0, 8'h00, TMO, 8'h5D);
        score("timeout_last_ack");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            int r, c, k;
            logic we;
            logic [7:0] d, rd;
            r = $urandom_range(0, 255); c = $urandom_range(0, 255);
            k = (i < 2) ? 0 : $urandom_range(0, 3);
            we = (i == 3); d = 8'($urandom); rd = 8'($urandom);
            push_exp(r, c, we, d, k, rd, 256, 256);
            run_op(r, c, we, d, k, rd);
            score("back_to_back");
        end
    endtask

    task automatic test_reset_mid_access;
        int n_done;
        @(negedge clk);
        rrr = 8'd7; crr = 8'd9; op_write = 1'b0; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (b_mem_req !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_pre: got mem_req %b want 1", b_mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if ({b_mem_req, b_op_ready, b_done, b_rdata} !== {3'b010, 8'h00}) begin
            n_bad++; $display("FAIL rst_mid_state: got req=%b rdy=%b done=%b rdata=%h want 0/1/0/00",
                              b_mem_req, b_op_ready, b_done, b_rdata);
        end
        m_rdata = 8'h00;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (b_done) n_done++;
        end
        n_vec++;
        if (n_done != 0) begin
            n_bad++; $display("FAIL rst_mid_no_done: got %0d done pulses want 0", n_done);
        end
        push_exp(7, 9, 1'b0, 8'h00, 2, 8'h5A, 256, 256);
        run_op(7, 9, 1'b0, 8'h00, 2, 8'h5A);
        score("rst_mid_fresh_load");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_write = 1'b0; mem_ack = 1'b0; sel = 1'b0;
        rrr = '0; crr = '0; rwr = '0; cwr = '0; wdata = '0; mem_rdata = '0;
        test_reset();
        test_idle();
        test_load_zero_wait();
        test_store_wait();
        test_range_fault();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
